// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch PC generator: FSM state encoding and BTB entry record.
package pc_gen_pkg;

    // Wide enough for the tag and target of any supported PC width.
    localparam int PC_FIELD_W = 64;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    typedef struct packed {
        logic                  valid;
        logic [PC_FIELD_W-1:0] tag;
        logic [PC_FIELD_W-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, write at the clock edge.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic [XLEN-1:0] target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int TAGW = XLEN - IDXW - 2;

    logic [TAGW-1:0]  tag_mem [DEPTH];
    logic [XLEN-1:0]  tgt_mem [DEPTH];
    logic [DEPTH-1:0] valid_bits;

    logic [IDXW-1:0] rd_idx;
    logic [IDXW-1:0] wr_idx;
    btb_entry_t      rd_entry;

    assign rd_idx = lookup_pc[IDXW+1:2];
    assign wr_idx = upd_pc[IDXW+1:2];

    // Valid bits live in flops so reset can clear every entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_bits <= '0;
        end else if (upd_valid) begin
            valid_bits[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid) begin
            tag_mem[wr_idx] <= upd_pc[XLEN-1:IDXW+2];
            tgt_mem[wr_idx] <= upd_target;
        end
    end

    always_comb begin
        rd_entry        = '0;
        rd_entry.valid  = valid_bits[rd_idx];
        rd_entry.tag    = PC_FIELD_W'(tag_mem[rd_idx]);
        rd_entry.target = PC_FIELD_W'(tgt_mem[rd_idx]);
    end

    assign hit    = rd_entry.valid && (rd_entry.tag == PC_FIELD_W'(lookup_pc[XLEN-1:IDXW+2]));
    assign target = rd_entry.target[XLEN-1:0];

    wire unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], rd_entry.target};

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with trap/redirect/halt control and optional BTB prediction.
// Define PC_GEN_BTB_EN to build the branch target buffer.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INC          = 4,
    parameter int              BTB_DEPTH    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            btb_upd_valid,
    input  logic [XLEN-1:0] btb_upd_pc,
    input  logic [XLEN-1:0] btb_upd_target,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            pred_taken,
    output logic            misalign
);

    pc_state_t       state;
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] seq_pc;
    logic            evt;
    logic [XLEN-1:0] evt_target;

`ifdef PC_GEN_BTB_EN
    pc_btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (pc_out),
        .hit        (btb_hit),
        .target     (btb_target),
        .upd_valid  (btb_upd_valid),
        .upd_pc     (btb_upd_pc),
        .upd_target (btb_upd_target)
    );
`else
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
    wire unused_btb = ^{btb_upd_valid, btb_upd_pc, btb_upd_target};
`endif

    assign seq_pc     = btb_hit ? btb_target : pc_out + XLEN'(INC);
    assign evt        = trap_valid | redirect_valid;
    assign evt_target = trap_valid ? trap_vector : redirect_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            pc_out     <= RESET_VECTOR;
            pc_valid   <= 1'b0;
            pred_taken <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid   <= 1'b1;
                    pred_taken <= 1'b0;
                end
                RUN: begin
                    if (evt) begin
                        pc_out     <= {evt_target[XLEN-1:2], 2'b00};
                        pred_taken <= 1'b0;
                        misalign   <= |evt_target[1:0];
                    end else if (halt_req) begin
                        state    <= HALTED;
                        pc_valid <= 1'b0;
                    end else if (pc_write) begin
                        pc_out     <= seq_pc;
                        pred_taken <= btb_hit;
                    end
                end
                HALTED: begin
                    // Only a trap or redirect wakes fetch; stalls and halts are ignored here.
                    if (evt) begin
                        state      <= RUN;
                        pc_valid   <= 1'b1;
                        pc_out     <= {evt_target[XLEN-1:2], 2'b00};
                        pred_taken <= 1'b0;
                        misalign   <= |evt_target[1:0];
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, reset corner cases, random vs. reference model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        halt_req = 1'b0;
    logic        btb_upd_valid = 1'b0;
    logic [31:0] btb_upd_pc = '0;
    logic [31:0] btb_upd_target = '0;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        pred_taken;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .halt_req       (halt_req),
        .btb_upd_valid  (btb_upd_valid),
        .btb_upd_pc     (btb_upd_pc),
        .btb_upd_target (btb_upd_target),
        .pc_out         (pc_out),
        .pc_valid       (pc_valid),
        .pred_taken     (pred_taken),
        .misalign       (misalign)
    );

    typedef struct {
        logic        pw;
        logic        rv;
        logic [31:0] rpc;
        logic        tv;
        logic [31:0] tvec;
        logic        halt;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_pred;
        logic        e_mis;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic pw, input logic rv, input logic [31:0] rpc,
                                input logic tv, input logic [31:0] tvec, input logic halt,
                                input logic [31:0] e_pc, input logic e_valid, input logic e_mis);
        vec_t v;
        v.pw = pw; v.rv = rv; v.rpc = rpc; v.tv = tv; v.tvec = tvec; v.halt = halt;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_pred = 1'b0; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_pred, input logic e_mis);
        $display("%s: pc=%h valid=%b pred=%b mis=%b", tag, pc_out, pc_valid, pred_taken, misalign);
        chk({tag, "_pc"}, pc_out, e_pc);
        chk({tag, "_valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
        chk({tag, "_pred"}, {31'd0, pred_taken}, {31'd0, e_pred});
        chk({tag, "_mis"}, {31'd0, misalign}, {31'd0, e_mis});
    endtask

    task automatic clear_inputs();
        pc_write = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0; halt_req = 1'b0;
        btb_upd_valid = 1'b0; redirect_pc = '0; trap_vector = '0;
        btb_upd_pc = '0; btb_upd_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_boot(input string tag);
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        check_all({tag, "_inreset"}, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        pc_write = 1'b1;
        tick();
        check_all({tag, "_boot"}, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // Reference model state: PC, running/halted, prediction and misalign flags, BTB contents.
    logic [31:0] m_pc;
    logic        m_run;
    logic        m_pred;
    logic        m_mis;
`ifdef PC_GEN_BTB_EN
    logic [31:0] m_btb_pc  [8];
    logic [31:0] m_btb_tgt [8];
    bit          m_btb_v   [8];
`endif

    initial begin
        vecs[0]  = mk(1, 0, 0,            0, 0,      0, 32'h4,        1, 0);
        vecs[1]  = mk(1, 0, 0,            0, 0,      0, 32'h8,        1, 0);
        vecs[2]  = mk(1, 0, 0,            0, 0,      0, 32'hC,        1, 0);
        vecs[3]  = mk(1, 0, 0,            0, 0,      0, 32'h10,       1, 0);
        vecs[4]  = mk(0, 1, 32'h103,      0, 0,      0, 32'h100,      1, 1);
        vecs[5]  = mk(0, 0, 0,            0, 0,      0, 32'h100,      1, 0);
        vecs[6]  = mk(1, 1, 32'h200,      1, 32'h80, 0, 32'h80,       1, 0);
        vecs[7]  = mk(0, 1, 32'h20,       0, 0,      0, 32'h20,       1, 0);
        vecs[8]  = mk(0, 0, 0,            0, 0,      1, 32'h20,       0, 0);
        vecs[9]  = mk(1, 0, 0,            0, 0,      1, 32'h20,       0, 0);
        vecs[10] = mk(0, 1, 32'h40,       0, 0,      0, 32'h40,       1, 0);
        vecs[11] = mk(0, 0, 0,            1, 32'h7F, 0, 32'h7C,       1, 1);
        vecs[12] = mk(0, 1, 32'hFFFFFFFC, 0, 0,      0, 32'hFFFFFFFC, 1, 0);
        vecs[13] = mk(1, 0, 0,            0, 0,      0, 32'h0,        1, 0);
        vecs[14] = mk(1, 0, 0,            0, 0,      0, 32'h4,        1, 0);
        vecs[15] = mk(1, 0, 0,            0, 0,      1, 32'h4,        0, 0);
        vecs[16] = mk(0, 0, 0,            1, 32'h301,0, 32'h300,      1, 1);
        vecs[17] = mk(1, 0, 0,            0, 0,      0, 32'h304,      1, 0);

        #1;
        check_all("por", 32'h0, 1'b0, 1'b0, 1'b0);
        reset_and_boot("r0");

        for (int i = 0; i < 18; i++) begin
            pc_write       = vecs[i].pw;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            trap_valid     = vecs[i].tv;
            trap_vector    = vecs[i].tvec;
            halt_req       = vecs[i].halt;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_pred, vecs[i].e_mis);
        end

        // Reset lands between a redirect being presented and the edge that would take it.
        clear_inputs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        trap_valid  = 1'b1;
        trap_vector = 32'h903;
        tick();
        rst = 1'b1;
        tick();
        check_all("boot_ignores", 32'h0, 1'b1, 1'b0, 1'b0);
        clear_inputs();
        tick();
        check_all("hold_after_boot", 32'h0, 1'b1, 1'b0, 1'b0);

        m_pc = 32'h0; m_run = 1'b1; m_pred = 1'b0; m_mis = 1'b0;
`ifdef PC_GEN_BTB_EN
        for (int k = 0; k < 8; k++) begin
            m_btb_v[k] = 1'b0; m_btb_pc[k] = '0; m_btb_tgt[k] = '0;
        end
`endif
        for (int n = 0; n < 400; n++) begin
            logic        hit;
            logic [31:0] tgt;
            logic [31:0] t;
            pc_write       = ($urandom_range(0, 3) != 0);
            trap_valid     = ($urandom_range(0, 19) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            halt_req       = ($urandom_range(0, 15) == 0);
            trap_vector    = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
            redirect_pc    = $urandom_range(0, 255);
            btb_upd_valid  = ($urandom_range(0, 3) == 0);
            btb_upd_pc     = $urandom_range(0, 63) << 2;
            btb_upd_target = $urandom_range(0, 63) << 2;

            hit = 1'b0;
            tgt = '0;
`ifdef PC_GEN_BTB_EN
            begin
                int idx;
                idx = int'((m_pc >> 2) % 8);
                hit = m_btb_v[idx] && (m_btb_pc[idx][31:2] == m_pc[31:2]);
                tgt = m_btb_tgt[idx];
            end
`endif
            m_mis = 1'b0;
            if (trap_valid || redirect_valid) begin
                t      = trap_valid ? trap_vector : redirect_pc;
                m_pc   = t & ~32'h3;
                m_run  = 1'b1;
                m_pred = 1'b0;
                m_mis  = (t % 4) != 0;
            end else if (m_run && halt_req) begin
                m_run = 1'b0;
            end else if (m_run && pc_write) begin
                m_pc   = hit ? tgt : m_pc + 32'd4;
                m_pred = hit;
            end
`ifdef PC_GEN_BTB_EN
            if (btb_upd_valid) begin
                int widx;
                widx = int'((btb_upd_pc >> 2) % 8);
                m_btb_v[widx]   = 1'b1;
                m_btb_pc[widx]  = btb_upd_pc;
                m_btb_tgt[widx] = btb_upd_target;
            end
`endif
            tick();
            check_all($sformatf("rnd%0d", n), m_pc, m_run, m_pred, m_mis);
        end

`ifdef PC_GEN_BTB_EN
        reset_and_boot("r1");
        btb_upd_valid  = 1'b1;
        btb_upd_pc     = 32'h8;
        btb_upd_target = 32'h100;
        pc_write       = 1'b1;
        tick();
        check_all("btb_a", 32'h4, 1'b1, 1'b0, 1'b0);
        btb_upd_valid = 1'b0;
        tick();
        check_all("btb_b", 32'h8, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("btb_hit", 32'h100, 1'b1, 1'b1, 1'b0);
        // Writing the entry being looked up this cycle must not affect this cycle's prediction.
        btb_upd_valid  = 1'b1;
        btb_upd_pc     = 32'h100;
        btb_upd_target = 32'h200;
        tick();
        check_all("btb_old", 32'h104, 1'b1, 1'b0, 1'b0);
        btb_upd_valid  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        check_all("btb_redir", 32'h100, 1'b1, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        tick();
        check_all("btb_new", 32'h200, 1'b1, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width in bits (minimum 8).
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter INC, default 4, sequential increment in bytes.
REQ-004 SHALL have parameter BTB_DEPTH, default 8, BTB entry count (power of two, 2..64).
REQ-005 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port: rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-007 SHALL have port: pc_write  input  1  1=advance PC; 0=stall (hold PC).
REQ-008 SHALL have port: redirect_valid  input  1  branch/jump resolved; load redirect_pc.
REQ-009 SHALL have port: redirect_pc  input  XLEN  redirect target.
REQ-010 SHALL have port: trap_valid  input  1  trap taken; load trap_vector.
REQ-011 SHALL have port: trap_vector  input  XLEN  trap handler address.
REQ-012 SHALL have port: halt_req  input  1  request fetch halt.
REQ-013 SHALL have port: btb_upd_valid / btb_upd_pc / btb_upd_target  input  1/XLEN/XLEN  BTB write.
REQ-014 SHALL have port: pc_out  output  XLEN  current fetch PC (registered).
REQ-015 SHALL have port: pc_valid  output  1  pc_out is a valid fetch address.
REQ-016 SHALL have port: pred_taken  output  1  next PC came from a BTB hit.
REQ-017 SHALL have port: misalign  output  1  one-cycle pulse: last redirect/trap target had nonzero bits [1:0].

Function
REQ-018 SHALL implement FSM states BOOT, RUN, HALTED.
REQ-019 BOOT: pc_out=RESET_VECTOR, pc_valid=0; unconditional transition to RUN next cycle.
REQ-020 RUN: pc_valid=1; next-PC priority trap_valid > redirect_valid > halt_req > pc_write > hold.
REQ-021 trap_valid: pc_out<=trap_vector with bits [1:0] cleared, same edge, regardless of pc_write.
REQ-022 redirect_valid (no trap): pc_out<=redirect_pc with bits [1:0] cleared, regardless of pc_write.
REQ-023 misalign SHALL be registered, high exactly one cycle after an accepted target with [1:0]!=0.
REQ-024 halt_req in RUN (no trap/redirect): pc_out held, transition to HALTED, pc_valid=0 from next cycle.
REQ-025 HALTED: pc_out held, pc_write and halt_req ignored; trap_valid or redirect_valid loads the target (same priority) and returns to RUN.
REQ-026 pc_write=1, no event: pc_out<=BTB target on hit (pred_taken=1), else pc_out+INC (pred_taken=0).
REQ-027 pc_write=0, no event: pc_out, pred_taken unchanged.
REQ-028 Sequential addition SHALL wrap modulo 2^XLEN (all-ones-ish PC + INC wraps to low addresses, no flag).
REQ-029 pred_taken SHALL be registered with pc_out; cleared on trap/redirect load.

Reset
REQ-030 rst=0 SHALL asynchronously set: state=BOOT, pc_out=RESET_VECTOR, pc_valid=0, pred_taken=0, misalign=0, all BTB valid bits=0.
REQ-031 Reset asserted mid-operation (any state, pending redirect) SHALL abandon it; no event survives reset.
REQ-032 First rising edge after rst deassertion SHALL execute BOOT->RUN only; inputs ignored that cycle.

Configuration
REQ-033 Macro PC_GEN_BTB_EN defined: direct-mapped BTB, index pc[log2(BTB_DEPTH)+1:2], tag remaining upper bits, per-entry valid; combinational lookup on pc_out.
REQ-034 BTB write on btb_upd_valid at clock edge, overwriting the indexed entry; same-cycle lookup of that index SHALL see the old contents.
REQ-035 Macro undefined: no BTB storage, btb_upd_* ignored, pred_taken tied 0, sequential path always pc_out+INC.

Structure
REQ-036 Shared package SHALL hold the FSM state enum (pc_state_t) and the BTB entry struct (valid, tag, target).
REQ-037 BTB SHALL be a sub-module pc_btb (lookup + update), instantiated only under PC_GEN_BTB_EN.

Verification
REQ-038 Reset release, pc_write=1 -> cycle 1 pc_out=0 pc_valid=0; then 0x4, 0x8, 0xC with pc_valid=1.
REQ-039 pc_out=0x10, pc_write=0, redirect_valid=1, redirect_pc=0x103 -> next pc_out=0x100, misalign=1 one cycle.
REQ-040 trap_valid and redirect_valid same cycle, vector 0x80, redirect 0x200 -> pc_out=0x80.
REQ-041 halt_req at pc 0x20 -> pc_out held 0x20, pc_valid=0; redirect to 0x40 -> RUN, pc_out=0x40, pc_valid=1.
REQ-042 XLEN=32, pc_out=0xFFFF_FFFC, pc_write=1 -> pc_out=0x0000_0000.
REQ-043 With PC_GEN_BTB_EN: update pc 0x8 -> target 0x100; reach pc 0x8 -> next pc_out=0x100, pred_taken=1.
